// File: rtl/uart_fifo_serial.sv
// Full-duplex UART with independent TX/RX FIFOs, configurable baud divisor and data width.
// Optional even parity enabled by defining UART_PARITY_EN (adds the parity_error output).

module uart_fifo_serial_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign pop_ok  = pop_i && !empty_o;
    // A pop frees the head slot this edge, so a push into a full FIFO still fits.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok)  rd_q <= rd_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_q] <= wdata_i;
    end
endmodule

module uart_fifo_serial #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            rx,
    output logic                            tx,
    input  logic [DATA_BITS-1:0]            tx_data,
    input  logic                            tx_write,
    output logic                            tx_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] tx_count,
    output logic                            tx_busy,
    output logic [DATA_BITS-1:0]            rx_data,
    input  logic                            rx_read,
    output logic                            rx_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
    output logic                            rx_overrun,
    output logic                            frame_error,
    input  logic                            clear_status
`ifdef UART_PARITY_EN
    ,
    output logic                            parity_error
`endif
);
`ifdef UART_PARITY_EN
    localparam int unsigned SW = DATA_BITS + 1;
`else
    localparam int unsigned SW = DATA_BITS;
`endif
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(SW+1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    // ---------------- TX ----------------
    state_e                tx_state_q, tx_state_d;
    logic [TW-1:0]         tx_cnt_q, tx_cnt_d;
    logic [IW-1:0]         tx_idx_q, tx_idx_d;
    logic [SW-1:0]         tx_shift_q, tx_shift_d, tx_frame;
    logic                  tx_q, tx_d, tx_pop, tx_empty, tx_bit_end;
    logic [DATA_BITS-1:0]  tx_head;

    uart_fifo_serial_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (tx_write),
        .wdata_i (tx_data),
        .pop_i   (tx_pop),
        .head_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

`ifdef UART_PARITY_EN
    assign tx_frame = {^tx_head, tx_head};
`else
    assign tx_frame = tx_head;
`endif
    assign tx_bit_end = (tx_cnt_q == TW'(CLKS_PER_BIT - 1));
    assign tx_busy    = (tx_state_q != IDLE);
    assign tx         = tx_q;

    // The line level is registered from the current state, so it trails the FSM by one clock.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        tx_d       = 1'b1;
        if (tx_state_q != IDLE) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + TW'(1);
        case (tx_state_q)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_frame;
                    tx_cnt_d   = '0;
                    tx_state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (tx_bit_end) begin
                    tx_idx_d   = '0;
                    tx_state_d = DATA;
                end
            end
            DATA: begin
                tx_d = tx_shift_q[0];
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_idx_d   = tx_idx_q + IW'(1);
                    if (tx_idx_q == IW'(SW - 1)) tx_state_d = STOP;
                end
            end
            STOP: begin
                if (tx_bit_end) tx_state_d = IDLE;
            end
            default: tx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    // ---------------- RX ----------------
    state_e                rx_state_q, rx_state_d;
    logic [TW-1:0]         rx_cnt_q, rx_cnt_d;
    logic [IW-1:0]         rx_idx_q, rx_idx_d;
    logic [SW-1:0]         rx_shift_q, rx_shift_d;
    logic                  rx_meta_q, rx_sync_q, rx_prev_q;
    logic                  rx_push, rx_full, rx_bit_end, rx_half;
    logic                  frame_set, overrun_set;
    logic                  rx_overrun_q, frame_error_q;
    logic [DATA_BITS-1:0]  rx_head, rx_last_q;

    uart_fifo_serial_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (rx_push),
        .wdata_i (rx_shift_q[DATA_BITS-1:0]),
        .pop_i   (rx_read),
        .head_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    assign rx_bit_end  = (rx_cnt_q == TW'(CLKS_PER_BIT - 1));
    assign rx_half     = (rx_cnt_q == TW'(CLKS_PER_BIT / 2 - 1));
    assign overrun_set = rx_push && rx_full && !rx_read;
    assign rx_data     = rx_empty ? rx_last_q : rx_head;
    assign rx_overrun  = rx_overrun_q;
    assign frame_error = frame_error_q;

`ifdef UART_PARITY_EN
    logic parity_set, parity_error_q;
    assign parity_error = parity_error_q;
`endif

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
`ifdef UART_PARITY_EN
        parity_set = 1'b0;
`endif
        if (rx_state_q != IDLE) rx_cnt_d = rx_cnt_q + TW'(1);
        case (rx_state_q)
            IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = START;
                end
            end
            START: begin
                if (rx_half) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_sync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[SW-1:1]};
                    rx_idx_d   = rx_idx_q + IW'(1);
                    if (rx_idx_q == IW'(SW - 1)) rx_state_d = STOP;
                end
            end
            STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_state_d = IDLE;
                    if (!rx_sync_q)
                        frame_set = 1'b1;
`ifdef UART_PARITY_EN
                    else if (^rx_shift_q)
                        parity_set = 1'b1;
`endif
                    else
                        rx_push = 1'b1;
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_prev_q     <= 1'b1;
            rx_state_q    <= IDLE;
            rx_cnt_q      <= '0;
            rx_idx_q      <= '0;
            rx_shift_q    <= '0;
            rx_last_q     <= '0;
            rx_overrun_q  <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef UART_PARITY_EN
            parity_error_q <= 1'b0;
`endif
        end else begin
            rx_meta_q     <= rx;
            rx_sync_q     <= rx_meta_q;
            rx_prev_q     <= rx_sync_q;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_idx_q      <= rx_idx_d;
            rx_shift_q    <= rx_shift_d;
            if (rx_read && !rx_empty) rx_last_q <= rx_head;
            rx_overrun_q  <= overrun_set | (rx_overrun_q & ~clear_status);
            frame_error_q <= frame_set | (frame_error_q & ~clear_status);
`ifdef UART_PARITY_EN
            parity_error_q <= parity_set | (parity_error_q & ~clear_status);
`endif
        end
    end
endmodule
